// File: rtl/pll_lock_ctrl_if.sv
// Control/status bundle between the PLL lock sequencer and the rest of the system.
// The slave modport is the sequencer's view; the master modport is the system's view.
interface pll_lock_ctrl_if;
    logic       pll_lock_in;
    logic       restart;
    logic       pll_rst;
    logic       rst_out;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_lost_cnt;

    modport master (
        output pll_lock_in,
        output restart,
        input  pll_rst,
        input  rst_out,
        input  ready,
        input  fail,
        input  retry_cnt,
        input  lock_lost_cnt
    );

    modport slave (
        input  pll_lock_in,
        input  restart,
        output pll_rst,
        output rst_out,
        output ready,
        output fail,
        output retry_cnt,
        output lock_lost_cnt
    );
endinterface

// File: rtl/pll_lock_ctrl.sv
// Power-up / recovery sequencer for one PLL: reset hold, lock wait with timeout,
// lock qualification, bounded retries and re-sequencing on loss of lock.
module pll_lock_ctrl #(
    parameter int RST_HOLD_CYC     = 250,
    parameter int LOCK_TIMEOUT_CYC = 25000,
    parameter int LOCK_STABLE_CYC  = 2500,
    parameter int MAX_RETRY        = 3,
    parameter int CNT_W            = 16
) (
    input  logic           clkin1,
    input  logic           rst,
    pll_lock_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE     = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAIL       = 3'd4
    } state_t;

    // Terminal timer values: a phase of N cycles ends when the timer shows N-1.
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       retry_cnt_q, retry_cnt_d;
    logic [7:0]       lock_lost_cnt_q, lock_lost_cnt_d;
    logic             pll_rst_q, pll_rst_d;
    logic             rst_out_q, rst_out_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             lock_s;

    // Synchronizer inputs: the raw lock is asynchronous and may glitch.
    always_comb begin
        sync1_d = bus.pll_lock_in;
        sync2_d = sync1_q;
    end

    assign lock_s = sync2_q;

    // Two-flop lock synchronizer.
    always_ff @(posedge clkin1 or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Next-state, phase timer and counter updates; restart overrides everything.
    always_comb begin
        state_d         = state_q;
        retry_cnt_d     = retry_cnt_q;
        lock_lost_cnt_d = lock_lost_cnt_q;
        if (bus.restart) begin
            state_d     = ST_RESET_HOLD;
            retry_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ST_RESET_HOLD: begin
                    if (timer_q == HOLD_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        state_d = ST_RESET_HOLD;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        retry_cnt_d = retry_cnt_q + 4'd1;
                        if (retry_cnt_d == RETRY_LIMIT) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_RESET_HOLD;
                        end
                    end else begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d     = ST_RUN;
                        retry_cnt_d = 4'd0;
                    end else begin
                        state_d = ST_STABLE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_RESET_HOLD;
                        if (lock_lost_cnt_q != 8'hFF) begin
                            lock_lost_cnt_d = lock_lost_cnt_q + 8'd1;
                        end else begin
                            lock_lost_cnt_d = lock_lost_cnt_q;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET_HOLD;
                end
            endcase
        end

        // A held restart re-enters RESET_HOLD every cycle, so the timer stays cleared.
        if (bus.restart || (state_d != state_q)) begin
            timer_d = {CNT_W{1'b0}};
        end else begin
            timer_d = timer_q + CNT_W'(1);
        end
    end

    // Output decode from the next state so outputs move on the same edge as the state.
    always_comb begin
        pll_rst_d = (state_d == ST_RESET_HOLD) || (state_d == ST_FAIL);
        ready_d   = (state_d == ST_RUN);
        rst_out_d = (state_d != ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    // State, timer, counters and registered outputs.
    always_ff @(posedge clkin1 or posedge rst) begin
        if (rst) begin
            state_q         <= ST_RESET_HOLD;
            timer_q         <= {CNT_W{1'b0}};
            retry_cnt_q     <= 4'd0;
            lock_lost_cnt_q <= 8'd0;
            pll_rst_q       <= 1'b1;
            rst_out_q       <= 1'b1;
            ready_q         <= 1'b0;
            fail_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            retry_cnt_q     <= retry_cnt_d;
            lock_lost_cnt_q <= lock_lost_cnt_d;
            pll_rst_q       <= pll_rst_d;
            rst_out_q       <= rst_out_d;
            ready_q         <= ready_d;
            fail_q          <= fail_d;
        end
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.rst_out       = rst_out_q;
    assign bus.ready         = ready_q;
    assign bus.fail          = fail_q;
    assign bus.retry_cnt     = retry_cnt_q;
    assign bus.lock_lost_cnt = lock_lost_cnt_q;

endmodule

// File: doc/pll_lock_ctrl.md
Name: pll_lock_ctrl

Overview:
Power-up and recovery sequencer for one on-chip PLL instance. It drives the PLL reset, waits for lock with a timeout, and qualifies lock as stable before releasing downstream logic. It retries a bounded number of times, and re-sequences on loss of lock. It sits beside the PLL wrapper and is clocked by the free-running 25 MHz input clock that feeds the PLL.

Parameters:
RST_HOLD_CYC, 250, cycles the PLL reset is held high per attempt (10 us at 25 MHz)
LOCK_TIMEOUT_CYC, 25000, cycles allowed in WAIT_LOCK before an attempt counts as failed (1 ms)
LOCK_STABLE_CYC, 2500, consecutive cycles synced lock must stay high before RUN (100 us)
MAX_RETRY, 3, failed attempts allowed before FAIL (1..15)
CNT_W, 16, width of the shared phase timer; must hold the largest of the three cycle parameters

Ports:
clkin1  in  1  free-running reference clock; also the PLL input clock
rst  in  1  asynchronous, active-high reset
pll_lock_in  in  1  PLL lock; asynchronous to clkin1 and may glitch
restart  in  1  single-cycle request to re-sequence from RESET_HOLD
pll_rst  out  1  to PLL reset input, active-high
rst_out  out  1  active-high reset for logic on PLL output clocks
ready  out  1  PLL locked and stable; downstream may run
fail  out  1  retry budget exhausted
retry_cnt  out  4  failed attempts since last RUN or restart
lock_lost_cnt  out  8  saturating count of lock losses seen in RUN

Behaviour:
- Reset is asynchronous and active-high; one clock.
- Reset values: state=RESET_HOLD, timer=0, pll_rst=1, rst_out=1, ready=0, fail=0, retry_cnt=0, lock_lost_cnt=0, sync flops=0.
- pll_lock_in passes through a 2-flop synchronizer to give lock_s. Only lock_s is used.
- All outputs are registered and change on the same edge as the state change they decode:
  - pll_rst=1 in RESET_HOLD and FAIL only.
  - ready=1 in RUN only; rst_out is its inverse.
  - fail=1 in FAIL only.
- The timer clears on every state entry and increments once per cycle while in that state.
- RESET_HOLD: lasts exactly RST_HOLD_CYC cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - lock_s=1 goes to STABLE.
  - If timer reaches LOCK_TIMEOUT_CYC-1 with lock_s=0, retry_cnt increments. If the new value equals MAX_RETRY, go to FAIL; otherwise go to RESET_HOLD.
  - If lock_s=1 on the timeout cycle, lock wins.
- STABLE:
  - lock_s=0 on any cycle goes to WAIT_LOCK with a fresh timeout. This is not a retry.
  - After LOCK_STABLE_CYC consecutive cycles with lock_s=1, go to RUN and clear retry_cnt.
- RUN: lock_s=0 increments lock_lost_cnt (saturating at 255, never wraps) and goes to RESET_HOLD.
- FAIL: held indefinitely. Only restart or rst leaves it.
- restart=1 in any state:
  - Goes to RESET_HOLD and clears retry_cnt.
  - Has priority over every other transition in the same cycle.
  - A lock drop in RUN on the same cycle does not increment lock_lost_cnt.
- restart held high for several cycles keeps the block in RESET_HOLD with the timer cleared. The hold length counts from restart deassertion.
- rst asserted mid-sequence returns all outputs to reset values immediately, without waiting for a clock edge.

Test Plan:
- Bench parameters for all scenarios: RST_HOLD=4, TIMEOUT=20, STABLE=8, MAX_RETRY=2.
- Nominal: release rst with lock low → pll_rst high for exactly 4 cycles. Raise lock 5 cycles later → ready=1 and rst_out=0 on the 10th edge after lock is first sampled high (2 sync + 8 stable); retry_cnt=0.
- Timeout: hold lock low → two attempts occur, each with 4 cycles of pll_rst high and 20 cycles low. After the second timeout: fail=1, pll_rst=1, retry_cnt=2, and the block stays there 1000 cycles.
- Glitch in STABLE: lock drops low for 1 cycle after 5 stable cycles → back to WAIT_LOCK, ready stays 0, retry_cnt unchanged. With lock then steady, ready rises 8 cycles after re-entering STABLE.
- Loss in RUN: drop lock → ready falls and rst_out rises 3 edges later, pll_rst pulses 4 cycles, lock_lost_cnt=1. Repeating 260 times leaves lock_lost_cnt=255.
- restart: pulse in FAIL → fail=0, pll_rst held 4 cycles, retry_cnt=0. Restart coincident with a lock drop in RUN → RESET_HOLD with lock_lost_cnt unchanged.
- Async reset: assert rst mid-WAIT_LOCK between clock edges → pll_rst=1, ready=0, counters 0 before the next edge.
